// File: rtl/riscv_pkg.sv
// Shared types for the RV32I decode stage.
//   opcode_t  : 7-bit major opcodes recognised by the decoder
//   alu_op_t  : 4-bit ALU operation handed to execute
//   imm_fmt_t : immediate format selector for riscv_imm_gen
//   dec_t     : registered decode bundle (immediate and PC kept separately)
//   NOP_INSTR : addi x0,x0,0, the instruction held after reset/flush
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OpLoad   = 7'h03,
    OpFence  = 7'h0F,
    OpImm    = 7'h13,
    OpAuipc  = 7'h17,
    OpStore  = 7'h23,
    OpReg    = 7'h33,
    OpLui    = 7'h37,
    OpBranch = 7'h63,
    OpJalr   = 7'h67,
    OpJal    = 7'h6F,
    OpSystem = 7'h73
  } opcode_t;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSll  = 4'd2,
    AluSlt  = 4'd3,
    AluSltu = 4'd4,
    AluXor  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluOr   = 4'd8,
    AluAnd  = 4'd9,
    AluLui  = 4'd10  // pass operand B (the U immediate) through
  } alu_op_t;

  typedef enum logic [2:0] {
    ImmNone = 3'd0,
    ImmI    = 3'd1,
    ImmS    = 3'd2,
    ImmB    = 3'd3,
    ImmU    = 3'd4,
    ImmJ    = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    alu_op_t    alu_op;
    logic       alu_src_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
  } dec_t;

  // funct3 -> ALU op for OP / OP-IMM. alt is instr[30]; it only selects SUB on OP.
  function automatic alu_op_t alu_from_funct(input logic [2:0] funct3, input logic alt,
                                             input logic is_reg);
    alu_op_t op;
    case (funct3)
      3'd0:    op = (is_reg && alt) ? AluSub : AluAdd;
      3'd1:    op = AluSll;
      3'd2:    op = AluSlt;
      3'd3:    op = AluSltu;
      3'd4:    op = AluXor;
      3'd5:    op = alt ? AluSra : AluSrl;
      3'd6:    op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational immediate generator.
//   instr : instruction bits [31:7] (opcode bits not needed)
//   fmt   : immediate format (I/S/B/U/J, or none -> 0)
//   imm   : 32-bit immediate, sign-extended from instr[31]
module riscv_imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
      ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU:    imm = {instr[31:12], 12'b0};
      ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage, one-entry pipeline register in front of a synchronous regfile.
// Accepts fetched instructions on in_valid/in_ready, drives the regfile read addresses
// combinationally and registers the decoded bundle so it lines up with the read data.
//   clk, rst (async, active-high)
//   in_valid/in_ready/in_instr/in_pc : fetch handshake
//   flush                            : kill held and incoming instruction
//   readReg1/readReg2                : regfile read addresses
//   out_valid/out_ready              : execute handshake
//   out_pc, out_rd/rs1/rs2, out_imm, out_alu_op and control flags : decoded bundle
//   out_illegal                      : only present when RV_DECODE_ILLEGAL_EN is defined
// Configuration macro: RV_DECODE_ILLEGAL_EN
module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      readReg1,
  output logic [4:0]      readReg2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [31:0]     out_imm,
  output logic [3:0]      out_alu_op,
  output logic            out_alu_src_imm,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
`ifdef RV_DECODE_ILLEGAL_EN
  output logic            out_illegal,
`endif
  output logic            out_jump
);

  // Register fields of the held NOP; all zero for addi x0,x0,0.
  localparam dec_t DecNop = '{
    rd:      NOP_INSTR[11:7],
    rs1:     NOP_INSTR[19:15],
    rs2:     NOP_INSTR[24:20],
    alu_op:  AluAdd,
    default: '0
  };

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     imm_q;
  dec_t            dec_q;
  dec_t            dec_d;
  logic [31:0]     imm_d;
  imm_fmt_t        fmt;
  logic            writes_rd;
  logic            bad;
  logic            accept;

  logic [2:0] funct3;
  logic [6:0] funct7;
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  riscv_imm_gen u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm_d)
  );

  always_comb begin
    dec_d     = DecNop;
    dec_d.rd  = in_instr[11:7];
    dec_d.rs1 = in_instr[19:15];
    dec_d.rs2 = in_instr[24:20];
    fmt       = ImmNone;
    writes_rd = 1'b0;
    bad       = 1'b0;

    case (in_instr[6:0])
      OpLui: begin
        fmt               = ImmU;
        dec_d.alu_op      = AluLui;
        dec_d.alu_src_imm = 1'b1;
        writes_rd         = 1'b1;
      end
      OpAuipc: begin
        fmt               = ImmU;
        dec_d.alu_src_imm = 1'b1;
        writes_rd         = 1'b1;
      end
      OpJal: begin
        fmt        = ImmJ;
        dec_d.jump = 1'b1;
        writes_rd  = 1'b1;
      end
      OpJalr: begin
        fmt               = ImmI;
        dec_d.jump        = 1'b1;
        dec_d.alu_src_imm = 1'b1;
        writes_rd         = 1'b1;
      end
      OpBranch: begin
        fmt          = ImmB;
        dec_d.branch = 1'b1;
        dec_d.alu_op = AluSub;
      end
      OpLoad: begin
        fmt               = ImmI;
        dec_d.mem_read    = 1'b1;
        dec_d.alu_src_imm = 1'b1;
        writes_rd         = 1'b1;
      end
      OpStore: begin
        fmt               = ImmS;
        dec_d.mem_write   = 1'b1;
        dec_d.alu_src_imm = 1'b1;
      end
      OpImm: begin
        fmt               = ImmI;
        dec_d.alu_op      = alu_from_funct(funct3, in_instr[30], 1'b0);
        dec_d.alu_src_imm = 1'b1;
        writes_rd         = 1'b1;
        // Shift-immediates carry funct7 in the upper immediate bits.
        bad = ((funct3 == 3'd1) && (funct7 != 7'h00)) ||
              ((funct3 == 3'd5) && (funct7 != 7'h00) && (funct7 != 7'h20));
      end
      OpReg: begin
        dec_d.alu_op = alu_from_funct(funct3, in_instr[30], 1'b1);
        writes_rd    = 1'b1;
        bad = !((funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
      end
      OpFence, OpSystem: ;  // treated as NOP
      default: bad = 1'b1;
    endcase

    // Register fields that hold immediate bits in this format read as x0.
    case (fmt)
      ImmU, ImmJ: begin
        dec_d.rs1 = 5'd0;
        dec_d.rs2 = 5'd0;
      end
      ImmB, ImmS: dec_d.rd = 5'd0;
      default: ;
    endcase

    if (bad) begin
      dec_d.alu_op      = AluAdd;
      dec_d.alu_src_imm = 1'b0;
      dec_d.mem_read    = 1'b0;
      dec_d.mem_write   = 1'b0;
      dec_d.branch      = 1'b0;
      dec_d.jump        = 1'b0;
      writes_rd         = 1'b0;
    end

    dec_d.reg_write = writes_rd && (dec_d.rd != 5'd0);
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Re-present the held registers while stalled so read data tracks late writebacks.
  assign readReg1 = accept ? in_instr[19:15] : dec_q.rs1;
  assign readReg2 = accept ? in_instr[24:20] : dec_q.rs2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      dec_q   <= DecNop;
    end else if (flush) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      dec_q   <= DecNop;
    end else if (accept) begin
      valid_q <= 1'b1;
      pc_q    <= in_pc;
      imm_q   <= imm_d;
      dec_q   <= dec_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef RV_DECODE_ILLEGAL_EN
  logic illegal_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (flush) begin
      illegal_q <= 1'b0;
    end else if (accept) begin
      illegal_q <= bad;
    end
  end
  assign out_illegal = illegal_q;
`endif

  assign out_valid       = valid_q;
  assign out_pc          = pc_q;
  assign out_imm         = imm_q;
  assign out_rd          = dec_q.rd;
  assign out_rs1         = dec_q.rs1;
  assign out_rs2         = dec_q.rs2;
  assign out_alu_op      = dec_q.alu_op;
  assign out_alu_src_imm = dec_q.alu_src_imm;
  assign out_reg_write   = dec_q.reg_write;
  assign out_mem_read    = dec_q.mem_read;
  assign out_mem_write   = dec_q.mem_write;
  assign out_branch      = dec_q.branch;
  assign out_jump        = dec_q.jump;

endmodule

// File: tb/tb_riscv_decode_stage.sv
module tb_riscv_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;
  logic [3:0]  out_alu_op;
  logic        out_alu_src_imm;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_branch;
  logic        out_jump;
`ifdef RV_DECODE_ILLEGAL_EN
  logic        out_illegal;
`endif

  always #5 clk = ~clk;

  riscv_decode_stage dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .in_pc           (in_pc),
    .flush           (flush),
    .readReg1        (readReg1),
    .readReg2        (readReg2),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_rd          (out_rd),
    .out_rs1         (out_rs1),
    .out_rs2         (out_rs2),
    .out_imm         (out_imm),
    .out_alu_op      (out_alu_op),
    .out_alu_src_imm (out_alu_src_imm),
    .out_reg_write   (out_reg_write),
    .out_mem_read    (out_mem_read),
    .out_mem_write   (out_mem_write),
    .out_branch      (out_branch),
`ifdef RV_DECODE_ILLEGAL_EN
    .out_illegal     (out_illegal),
`endif
    .out_jump        (out_jump)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ctl = {alu_src_imm, reg_write, mem_read, mem_write, branch, jump}
  // mask = which of {rd, rs1, rs2, imm} are defined for this encoding
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [5:0]  ctl;
    logic        ill;
    logic [3:0]  mask;
  } vec_t;

  localparam int NVec = 14;
  vec_t vecs [NVec];

  function automatic logic [5:0] ctl_now();
    return {out_alu_src_imm, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump};
  endfunction

  initial begin
    logic [31:0] w;

    vecs[0]  = '{"addi",   32'h00A30293, 5'd5,  5'd6, 5'd0, 32'd10,        4'd0,  6'b110000, 1'b0, 4'b1101};
    vecs[1]  = '{"lui",    32'h123450B7, 5'd1,  5'd0, 5'd0, 32'h12345000,  4'd10, 6'b110000, 1'b0, 4'b1111};
    vecs[2]  = '{"auipc",  32'hFFFFF197, 5'd3,  5'd0, 5'd0, 32'hFFFFF000,  4'd0,  6'b110000, 1'b0, 4'b1111};
    vecs[3]  = '{"jal",    32'h010000EF, 5'd1,  5'd0, 5'd0, 32'd16,        4'd0,  6'b010001, 1'b0, 4'b1111};
    vecs[4]  = '{"jalr_x0",32'h00008067, 5'd0,  5'd1, 5'd0, 32'd0,         4'd0,  6'b100001, 1'b0, 4'b1101};
    vecs[5]  = '{"beq",    32'hFE208CE3, 5'd0,  5'd1, 5'd2, 32'hFFFFFFF8,  4'd1,  6'b000010, 1'b0, 4'b1111};
    vecs[6]  = '{"sw",     32'h00512423, 5'd0,  5'd2, 5'd5, 32'd8,         4'd0,  6'b100100, 1'b0, 4'b1111};
    vecs[7]  = '{"add_x0", 32'h00208033, 5'd0,  5'd1, 5'd2, 32'd0,         4'd0,  6'b000000, 1'b0, 4'b1110};
    vecs[8]  = '{"sub",    32'h405201B3, 5'd3,  5'd4, 5'd5, 32'd0,         4'd1,  6'b010000, 1'b0, 4'b1110};
    vecs[9]  = '{"srai",   32'h4033D313, 5'd6,  5'd7, 5'd0, 32'h00000403,  4'd7,  6'b110000, 1'b0, 4'b1101};
    vecs[10] = '{"mul",    32'h02208033, 5'd0,  5'd1, 5'd2, 32'd0,         4'd0,  6'b000000, 1'b1, 4'b1110};
    vecs[11] = '{"ecall",  32'h00000073, 5'd0,  5'd0, 5'd0, 32'd0,         4'd0,  6'b000000, 1'b0, 4'b0000};
    vecs[12] = '{"allone", 32'hFFFFFFFF, 5'd0,  5'd0, 5'd0, 32'd0,         4'd0,  6'b000000, 1'b1, 4'b0000};
    vecs[13] = '{"lw",     32'hFFC12383, 5'd7,  5'd2, 5'd0, 32'hFFFFFFFC,  4'd0,  6'b111000, 1'b0, 4'b1101};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset readReg1", {27'd0, readReg1}, 32'd0);
    chk("reset readReg2", {27'd0, readReg2}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_ctl", {26'd0, ctl_now()}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // addi x5,x6,10
    in_valid = 1'b1; in_instr = 32'h00A30293; in_pc = 32'h100;
    #1 chk("addi readReg1 at accept", {27'd0, readReg1}, 32'd6);
    @(posedge clk); #1;
    chk("addi out_valid", {31'd0, out_valid}, 32'd1);
    chk("addi out_rd", {27'd0, out_rd}, 32'd5);
    chk("addi out_imm", out_imm, 32'd10);
    chk("addi reg_write", {31'd0, out_reg_write}, 32'd1);
    chk("addi alu_src_imm", {31'd0, out_alu_src_imm}, 32'd1);
    chk("addi out_pc", out_pc, 32'h100);

    // lw x7,-4(x2) then stall three cycles with another instruction offered
    in_instr = 32'hFFC12383; in_pc = 32'h104;
    @(posedge clk); #1;
    out_ready = 1'b0; in_instr = 32'h00208033; in_pc = 32'h108;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall readReg1", {27'd0, readReg1}, 32'd2);
      chk("stall out_imm", out_imm, 32'hFFFFFFFC);
      chk("stall out_rd", {27'd0, out_rd}, 32'd7);
      chk("stall mem_read", {31'd0, out_mem_read}, 32'd1);
      chk("stall out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall out_pc", out_pc, 32'h104);
      @(posedge clk); #1;
    end
    // drain
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain out_rd held", {27'd0, out_rd}, 32'd7);
    chk("drain out_imm held", out_imm, 32'hFFFFFFFC);

    // flush with in_valid: held sub is killed, incoming lw discarded
    in_valid = 1'b1; in_instr = 32'h405201B3; in_pc = 32'h200;
    @(posedge clk); #1;
    chk("pre-flush out_rd", {27'd0, out_rd}, 32'd3);
    flush = 1'b1; in_instr = 32'hFFC12383; in_pc = 32'h204;
    #1;
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush readReg1 not accepted", {27'd0, readReg1}, 32'd4);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush out_rs1", {27'd0, out_rs1}, 32'd0);
    chk("flush out_rs2", {27'd0, out_rs2}, 32'd0);
    chk("flush out_rd not latched", {27'd0, out_rd}, 32'd0);
    in_valid = 1'b0;
    #1 chk("flush readReg1", {27'd0, readReg1}, 32'd0);
    in_valid = 1'b1; in_instr = 32'h00A30293; in_pc = 32'h300;
    @(posedge clk); #1;
    chk("post-flush out_valid", {31'd0, out_valid}, 32'd1);
    chk("post-flush out_rd", {27'd0, out_rd}, 32'd5);

    // table-driven decode, back-to-back
    for (int i = 0; i < NVec; i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(i * 4);
      w = vecs[i].instr;
      #1 chk({vecs[i].name, " readReg1"}, {27'd0, readReg1}, {27'd0, w[19:15]});
      chk({vecs[i].name, " readReg2"}, {27'd0, readReg2}, {27'd0, w[24:20]});
      @(posedge clk); #1;
      chk({vecs[i].name, " out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({vecs[i].name, " out_pc"}, out_pc, 32'h1000 + 32'(i * 4));
      chk({vecs[i].name, " ctl"}, {26'd0, ctl_now()}, {26'd0, vecs[i].ctl});
      chk({vecs[i].name, " alu_op"}, {28'd0, out_alu_op}, {28'd0, vecs[i].alu});
      if (vecs[i].mask[3]) chk({vecs[i].name, " rd"}, {27'd0, out_rd}, {27'd0, vecs[i].rd});
      if (vecs[i].mask[2]) chk({vecs[i].name, " rs1"}, {27'd0, out_rs1}, {27'd0, vecs[i].rs1});
      if (vecs[i].mask[1]) chk({vecs[i].name, " rs2"}, {27'd0, out_rs2}, {27'd0, vecs[i].rs2});
      if (vecs[i].mask[0]) chk({vecs[i].name, " imm"}, out_imm, vecs[i].imm);
`ifdef RV_DECODE_ILLEGAL_EN
      chk({vecs[i].name, " illegal"}, {31'd0, out_illegal}, {31'd0, vecs[i].ill});
`endif
    end

    // asynchronous reset while a stalled beq is held
    in_instr = 32'hFE208CE3; in_pc = 32'h400;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
    chk("pre-reset readReg2", {27'd0, readReg2}, 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("async reset readReg1", {27'd0, readReg1}, 32'd0);
    chk("async reset readReg2", {27'd0, readReg2}, 32'd0);
    chk("async reset branch", {31'd0, out_branch}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
